// File: rtl/ps2_tx_bank.sv
// ps2_tx_bank
//   Bank of NUM_CH independent PS/2 device-side transmitters. Each channel
//   has its own byte FIFO, and all channels share one half-bit tick
//   prescaler on the system clock.
//
//   Ports:
//     clk, reset_n      system clock, asynchronous active-low reset
//     wr_stb/wr_chan/wr_data  byte write into FIFO wr_chan (ignored if
//                       wr_chan >= NUM_CH)
//     clr_overflow      per-channel pulse clearing the sticky overflow flag
//     ps2_clk_o/ps2_data_o  PS/2 line pair per channel, idle high
//     fifo_full/fifo_empty  FIFO status per channel
//     overflow          sticky per channel: a byte was dropped on a full FIFO
//     busy              per channel: transmitter not IDLE
//
//   Optional macro PS2_TX_INHIBIT_EN adds input ps2_clk_i[NUM_CH]. This is
//   the sampled clock line. A host pulling it low during START..PARITY
//   aborts the frame. The channel then waits in HOLD until the line has
//   been high for 2 ticks, and resends the latched byte.
module ps2_tx_bank #(
  parameter int NUM_CH    = 2,
  parameter int FIFO_BITS = 3,
  parameter int CLK_DIV   = 1000,
  parameter int GAP_TICKS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_stb,
  input  logic [2:0]        wr_chan,
  input  logic [7:0]        wr_data,
  input  logic [NUM_CH-1:0] clr_overflow,
`ifdef PS2_TX_INHIBIT_EN
  input  logic [NUM_CH-1:0] ps2_clk_i,
`endif
  output logic [NUM_CH-1:0] ps2_clk_o,
  output logic [NUM_CH-1:0] ps2_data_o,
  output logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] fifo_empty,
  output logic [NUM_CH-1:0] overflow,
  output logic [NUM_CH-1:0] busy
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int PTR_W = FIFO_BITS + 1;
  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_GAP
`ifdef PS2_TX_INHIBIT_EN
    , ST_HOLD
`endif
  } state_t;

  // Shared half-bit prescaler
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick;

  always_comb begin
    tick    = (presc_q == PRE_W'(CLK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [2:0] CH_IDX = 3'(gi);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]       rd_byte;
    logic             full, empty, sel, push, pop, line_ok;
    state_t           state_q, state_d;
    logic             half_q, half_d;
    logic [2:0]       idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic             clk_q, clk_d, data_q, data_d;
    logic             ovf_q, ovf_d;

`ifdef PS2_TX_INHIBIT_EN
    logic sync1_q, sync2_q, hold_q, hold_d;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= ps2_clk_i[gi];
        sync2_q <= sync1_q;
      end
    end
    // While the host holds the line low, no new frame may begin.
    assign line_ok = sync2_q;
`else
    assign line_ok = 1'b1;
`endif

    assign full    = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                     (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_byte = mem_q[rd_ptr_q[FIFO_BITS-1:0]];
    assign sel     = wr_stb && (wr_chan == CH_IDX);

    always_comb begin
      state_d = state_q;
      half_d  = half_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      byte_d  = byte_q;
      par_d   = par_q;
      pop     = 1'b0;
`ifdef PS2_TX_INHIBIT_EN
      hold_d  = hold_q;
`endif
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (!empty && line_ok) begin
              pop     = 1'b1;
              state_d = ST_START;
              half_d  = 1'b0;
            end
          end
          ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
            if (!half_q) begin
              half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              case (state_q)
                ST_START: begin
                  state_d = ST_DATA;
                  idx_d   = 3'd0;
                end
                ST_DATA: begin
                  if (idx_q == 3'd7) state_d = ST_PARITY;
                  else               idx_d   = idx_q + 3'd1;
                end
                ST_PARITY: state_d = ST_STOP;
                default: begin
                  state_d = ST_GAP;
                  gap_d   = '0;
                end
              endcase
            end
          end
          ST_GAP: begin
            if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
              // The last gap tick goes straight into the next frame when a
              // byte is waiting, so back-to-back frames get exactly
              // GAP_TICKS idle ticks.
              if (!empty && line_ok) begin
                pop     = 1'b1;
                state_d = ST_START;
                half_d  = 1'b0;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
`ifdef PS2_TX_INHIBIT_EN
          ST_HOLD: begin
            // The line must be seen high on two consecutive ticks.
            if (sync2_q) begin
              if (hold_q) begin
                state_d = ST_START;
                half_d  = 1'b0;
              end else begin
                hold_d = 1'b1;
              end
            end else begin
              hold_d = 1'b0;
            end
          end
`endif
          default: state_d = ST_IDLE;
        endcase
`ifdef PS2_TX_INHIBIT_EN
        // Line low while we release the clock means the host is inhibiting.
        if ((state_q == ST_START || state_q == ST_DATA || state_q == ST_PARITY) &&
            clk_q && !sync2_q) begin
          state_d = ST_HOLD;
          half_d  = 1'b0;
          hold_d  = 1'b0;
        end
`endif
      end
      if (pop) begin
        byte_d = rd_byte;
        par_d  = ~^rd_byte;
      end

      // Decode outputs from the next state so the line changes one cycle
      // after the tick.
      clk_d  = 1'b1;
      data_d = 1'b1;
      case (state_d)
        ST_START: begin
          data_d = 1'b0;
          clk_d  = ~half_d;
        end
        ST_DATA: begin
          data_d = byte_d[idx_d];
          clk_d  = ~half_d;
        end
        ST_PARITY: begin
          data_d = par_d;
          clk_d  = ~half_d;
        end
        ST_STOP: clk_d = ~half_d;
        default: ;
      endcase

      // A pop in the same cycle frees a slot, so a write to a full FIFO is
      // still accepted then.
      push     = sel && (!full || pop);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      // If a set and a clear arrive together, the set wins.
      ovf_d = ovf_q;
      if (clr_overflow[gi]) ovf_d = 1'b0;
      if (sel && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        state_q  <= ST_IDLE;
        half_q   <= 1'b0;
        idx_q    <= 3'd0;
        gap_q    <= '0;
        byte_q   <= 8'h00;
        par_q    <= 1'b0;
        clk_q    <= 1'b1;
        data_q   <= 1'b1;
        ovf_q    <= 1'b0;
`ifdef PS2_TX_INHIBIT_EN
        hold_q   <= 1'b0;
`endif
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        state_q  <= state_d;
        half_q   <= half_d;
        idx_q    <= idx_d;
        gap_q    <= gap_d;
        byte_q   <= byte_d;
        par_q    <= par_d;
        clk_q    <= clk_d;
        data_q   <= data_d;
        ovf_q    <= ovf_d;
`ifdef PS2_TX_INHIBIT_EN
        hold_q   <= hold_d;
`endif
      end
    end

    assign ps2_clk_o[gi]  = clk_q;
    assign ps2_data_o[gi] = data_q;
    assign fifo_full[gi]  = full;
    assign fifo_empty[gi] = empty;
    assign overflow[gi]   = ovf_q;
    assign busy[gi]       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_ps2_tx_bank.sv
// Testbench for ps2_tx_bank (NUM_CH=2, FIFO_BITS=3, CLK_DIV=4, GAP_TICKS=4).
// A line monitor decodes 11-bit frames from each channel. Bytes the bench
// expects are queued when written, then popped and compared as frames arrive.
module tb_ps2_tx_bank;
  localparam int NCH       = 2;
  localparam int CDIV      = 4;
  localparam int GAP       = 4;
  localparam int FRAME_CYC = (22 + GAP) * CDIV;

  typedef struct {
    logic [10:0] raw;
    int          t0;
  } frame_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           wr_stb = 1'b0;
  logic [2:0]     wr_chan = 3'd0;
  logic [7:0]     wr_data = 8'h00;
  logic [NCH-1:0] clr_overflow = '0;
`ifdef PS2_TX_INHIBIT_EN
  logic [NCH-1:0] ps2_clk_i = '1;
`endif
  logic [NCH-1:0] ps2_clk_o, ps2_data_o, fifo_full, fifo_empty, overflow, busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  frame_t     rx0[$];
  frame_t     rx1[$];

  ps2_tx_bank #(.NUM_CH(NCH), .FIFO_BITS(3), .CLK_DIV(CDIV), .GAP_TICKS(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .wr_stb(wr_stb), .wr_chan(wr_chan),
    .wr_data(wr_data), .clr_overflow(clr_overflow),
`ifdef PS2_TX_INHIBIT_EN
    .ps2_clk_i(ps2_clk_i),
`endif
    .ps2_clk_o(ps2_clk_o), .ps2_data_o(ps2_data_o), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Line monitor. It samples on the falling system clock edge and takes the
  // data bit at each falling edge of the PS/2 clock. A clock held high too
  // long discards any partial frame (reset or abort).
  int             cyc = 0;
  int             bad_low = 0;
  logic [NCH-1:0] prev_clk = '1;
  logic [10:0]    sh [NCH];
  int             nb [NCH];
  int             lowc [NCH];
  int             highc [NCH];
  int             t0s [NCH];

  always @(negedge clk) begin
    frame_t f;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (!reset_n) begin
        nb[c] = 0; lowc[c] = 0; highc[c] = 0;
      end else if (ps2_clk_o[c]) begin
        if (!prev_clk[c] && lowc[c] != CDIV) bad_low++;
        highc[c]++;
        if (highc[c] > 2 * CDIV) nb[c] = 0;
      end else begin
        if (prev_clk[c]) begin
          if (nb[c] == 0) t0s[c] = cyc;
          sh[c][nb[c]] = ps2_data_o[c];
          nb[c]++;
          lowc[c] = 1;
          if (nb[c] == 11) begin
            f.raw = sh[c];
            f.t0  = t0s[c];
            if (c == 0) rx0.push_back(f);
            else        rx1.push_back(f);
            nb[c] = 0;
          end
        end else begin
          lowc[c]++;
        end
        highc[c] = 0;
      end
      prev_clk[c] = ps2_clk_o[c];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    exp0.delete(); exp1.delete(); rx0.delete(); rx1.delete();
  endtask

  task automatic wr_byte(input int ch, input logic [7:0] d, input bit expect_out);
    wr_stb = 1'b1; wr_chan = 3'(ch); wr_data = d;
    if (expect_out) begin
      if (ch == 0) exp0.push_back(d);
      else         exp1.push_back(d);
    end
    step(1);
    wr_stb = 1'b0;
  endtask

  task automatic get_frame(input int ch, input int budget, output frame_t f, output bit got);
    int n = 0;
    got = 1'b0;
    f.raw = '0; f.t0 = 0;
    while (n < budget && ((ch == 0) ? rx0.size() : rx1.size()) == 0) begin
      step(1); n++;
    end
    if (ch == 0 && rx0.size() > 0) begin f = rx0.pop_front(); got = 1'b1; end
    if (ch == 1 && rx1.size() > 0) begin f = rx1.pop_front(); got = 1'b1; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(3);
    checks++; if (ps2_clk_o !== 2'b11)  begin failures++; $display("FAIL reset_clk got=%b exp=11", ps2_clk_o); end
    checks++; if (ps2_data_o !== 2'b11) begin failures++; $display("FAIL reset_data got=%b exp=11", ps2_data_o); end
    checks++; if (fifo_full !== 2'b00)  begin failures++; $display("FAIL reset_full got=%b exp=00", fifo_full); end
    checks++; if (fifo_empty !== 2'b11) begin failures++; $display("FAIL reset_empty got=%b exp=11", fifo_empty); end
    checks++; if (overflow !== 2'b00)   begin failures++; $display("FAIL reset_ovf got=%b exp=00", overflow); end
    checks++; if (busy !== 2'b00)       begin failures++; $display("FAIL reset_busy got=%b exp=00", busy); end
    do_reset();
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    int          seq [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    logic [10:0] exp_raw;
    logic [7:0]  e;
    frame_t      f;
    bit          got;
    int          n = 0;
    int          cnt = 0;
    for (int i = 0; i < 11; i++) exp_raw[i] = (seq[i] != 0);
    wr_byte(0, 8'h1C, 1'b1);
    while (!busy[0] && n < 50) begin step(1); n++; end
    while (busy[0] && cnt < 400) begin step(1); cnt++; end
    checks++; if (cnt !== FRAME_CYC) begin failures++; $display("FAIL busy_len got=%0d exp=%0d", cnt, FRAME_CYC); end
    get_frame(0, 50, f, got);
    checks++;
    if (!got) begin
      failures++; $display("FAIL frame_1c got=none exp=frame");
    end else begin
      e = exp0.pop_front();
      checks++; if (f.raw !== exp_raw) begin failures++; $display("FAIL seq_1c got=%b exp=%b", f.raw, exp_raw); end
      checks++; if (f.raw[8:1] !== e) begin failures++; $display("FAIL byte_1c got=%h exp=%h", f.raw[8:1], e); end
    end
    checks++; if (bad_low !== 0) begin failures++; $display("FAIL low_width bad_pulses=%0d exp=0", bad_low); end
    $display("frame ch0 byte=%h raw=%b busy_cycles=%0d", f.raw[8:1], f.raw, cnt);
  endtask

  task automatic test_parity();
    frame_t     f [2];
    bit         got;
    logic [7:0] e;
    int         n = 0;
    int         lows = 0;
    wr_byte(1, 8'h00, 1'b1);
    wr_byte(1, 8'hFF, 1'b1);
    while (rx1.size() < 2 && n < 3 * FRAME_CYC) begin
      if (ps2_clk_o[0] !== 1'b1 || ps2_data_o[0] !== 1'b1) lows++;
      step(1); n++;
    end
    checks++; if (lows !== 0) begin failures++; $display("FAIL ch0_quiet got=%0d exp=0", lows); end
    for (int k = 0; k < 2; k++) begin
      get_frame(1, 10, f[k], got);
      checks++;
      if (!got || exp1.size() == 0) begin
        failures++; $display("FAIL parity_frame%0d got=none exp=frame", k);
      end else begin
        e = exp1.pop_front();
        checks++; if (f[k].raw[8:1] !== e)  begin failures++; $display("FAIL parity_byte got=%h exp=%h", f[k].raw[8:1], e); end
        checks++; if (f[k].raw[9] !== 1'b1) begin failures++; $display("FAIL parity_bit byte=%h got=%b exp=1", e, f[k].raw[9]); end
        checks++; if (f[k].raw[10] !== 1'b1 || f[k].raw[0] !== 1'b0) begin
          failures++; $display("FAIL framing got=%b exp=start0 stop1", f[k].raw);
        end
        $display("frame ch1 byte=%h parity=%b t0=%0d", f[k].raw[8:1], f[k].raw[9], f[k].t0);
      end
    end
    checks++; if (f[1].t0 - f[0].t0 !== FRAME_CYC) begin
      failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", f[1].t0 - f[0].t0, FRAME_CYC);
    end
  endtask

  task automatic test_overflow();
    frame_t     f;
    bit         got;
    logic [7:0] e;
    int         n = 0;
    wr_byte(0, 8'h11, 1'b1);
    while (!busy[0] && n < 50) begin step(1); n++; end
    for (int i = 0; i < 9; i++) begin
      wr_byte(0, 8'(32 + i), i < 8);
      if (i == 7) begin
        checks++; if (fifo_full[0] !== 1'b1) begin failures++; $display("FAIL full_after8 got=%b exp=1", fifo_full[0]); end
        checks++; if (overflow[0] !== 1'b0)  begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow[0]); end
      end
    end
    checks++; if (overflow[0] !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow[0]); end
    checks++; if (overflow[1] !== 1'b0) begin failures++; $display("FAIL ovf_ch1 got=%b exp=0", overflow[1]); end
    clr_overflow = 2'b01;
    step(1);
    clr_overflow = 2'b00;
    checks++; if (overflow[0] !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow[0]); end
    for (int k = 0; k < 9; k++) begin
      get_frame(0, 3 * FRAME_CYC, f, got);
      checks++;
      if (!got || exp0.size() == 0) begin
        failures++; $display("FAIL ovf_frame%0d got=none exp=frame", k);
      end else begin
        e = exp0.pop_front();
        checks++; if (f.raw[8:1] !== e) begin failures++; $display("FAIL order%0d got=%h exp=%h", k, f.raw[8:1], e); end
        $display("frame ch0 #%0d byte=%h", k, f.raw[8:1]);
      end
    end
    step(2 * FRAME_CYC);
    checks++; if (fifo_empty !== 2'b11) begin failures++; $display("FAIL empty_end got=%b exp=11", fifo_empty); end
    checks++; if (rx0.size() !== 0) begin failures++; $display("FAIL extra_frames got=%0d exp=0", rx0.size()); end
  endtask

  task automatic test_concurrent();
    frame_t     f0, f1;
    bit         g0, g1;
    logic [7:0] e0, e1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_byte(0, 8'(8'h31 + i), 1'b1);
      wr_byte(1, 8'(8'h41 + i), 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      get_frame(0, 3 * FRAME_CYC, f0, g0);
      get_frame(1, 3 * FRAME_CYC, f1, g1);
      checks++;
      if (!g0 || !g1 || exp0.size() == 0 || exp1.size() == 0) begin
        failures++; $display("FAIL conc_frame%0d got=%0d/%0d exp=1/1", k, g0, g1);
      end else begin
        e0 = exp0.pop_front();
        e1 = exp1.pop_front();
        checks++; if (f0.raw[8:1] !== e0) begin failures++; $display("FAIL conc_ch0 got=%h exp=%h", f0.raw[8:1], e0); end
        checks++; if (f1.raw[8:1] !== e1) begin failures++; $display("FAIL conc_ch1 got=%h exp=%h", f1.raw[8:1], e1); end
        checks++; if (f0.t0 !== f1.t0) begin failures++; $display("FAIL conc_align got=%0d exp=%0d", f1.t0, f0.t0); end
        $display("frame pair ch0=%h ch1=%h t0=%0d/%0d", f0.raw[8:1], f1.raw[8:1], f0.t0, f1.t0);
      end
    end
  endtask

  task automatic test_reset_mid();
    frame_t     f;
    bit         got;
    logic [7:0] e;
    int         n = 0;
    wr_byte(0, 8'h5A, 1'b1);
    wr_byte(0, 8'h66, 1'b1);
    while (nb[0] != 5 && n < 400) begin step(1); n++; end
    checks++; if (nb[0] !== 5) begin failures++; $display("FAIL reach_bit4 got=%0d exp=5", nb[0]); end
    step(6);
    reset_n = 1'b0;
    #1;
    checks++; if (ps2_clk_o !== 2'b11 || ps2_data_o !== 2'b11) begin
      failures++; $display("FAIL mid_reset_lines got=%b/%b exp=11/11", ps2_clk_o, ps2_data_o);
    end
    checks++; if (fifo_empty !== 2'b11) begin failures++; $display("FAIL mid_reset_empty got=%b exp=11", fifo_empty); end
    checks++; if (busy !== 2'b00) begin failures++; $display("FAIL mid_reset_busy got=%b exp=00", busy); end
    exp0.delete(); rx0.delete();
    step(3);
    reset_n = 1'b1;
    step(300);
    checks++; if (rx0.size() !== 0 || busy !== 2'b00) begin
      failures++; $display("FAIL no_resume got=%0d frames busy=%b exp=0 frames busy=00", rx0.size(), busy);
    end
    wr_byte(0, 8'h77, 1'b1);
    get_frame(0, 3 * FRAME_CYC, f, got);
    checks++;
    if (!got || exp0.size() == 0) begin
      failures++; $display("FAIL post_reset_frame got=none exp=frame");
    end else begin
      e = exp0.pop_front();
      checks++; if (f.raw[8:1] !== e) begin failures++; $display("FAIL post_reset_byte got=%h exp=%h", f.raw[8:1], e); end
      $display("frame ch0 after reset byte=%h", f.raw[8:1]);
    end
  endtask

`ifdef PS2_TX_INHIBIT_EN
  task automatic test_inhibit();
    frame_t     f [2];
    bit         got;
    logic [7:0] e;
    int         n = 0;
    do_reset();
    wr_byte(0, 8'hA5, 1'b1);
    wr_byte(0, 8'h3C, 1'b1);
    while (nb[0] != 3 && n < 400) begin step(1); n++; end
    ps2_clk_i[0] = 1'b0;
    step(20);
    checks++; if (busy[0] !== 1'b1 || ps2_clk_o[0] !== 1'b1 || ps2_data_o[0] !== 1'b1) begin
      failures++; $display("FAIL hold_state got=busy%b clk%b data%b exp=111", busy[0], ps2_clk_o[0], ps2_data_o[0]);
    end
    checks++; if (fifo_empty[0] !== 1'b0) begin failures++; $display("FAIL hold_fifo got=%b exp=0", fifo_empty[0]); end
    step(20);
    ps2_clk_i[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      get_frame(0, 4 * FRAME_CYC, f[k], got);
      checks++;
      if (!got || exp0.size() == 0) begin
        failures++; $display("FAIL inh_frame%0d got=none exp=frame", k);
      end else begin
        e = exp0.pop_front();
        checks++; if (f[k].raw[8:1] !== e) begin failures++; $display("FAIL inh_byte got=%h exp=%h", f[k].raw[8:1], e); end
        $display("frame ch0 after inhibit byte=%h", f[k].raw[8:1]);
      end
    end
    checks++; if (f[1].t0 - f[0].t0 !== FRAME_CYC) begin
      failures++; $display("FAIL inh_spacing got=%0d exp=%0d", f[1].t0 - f[0].t0, FRAME_CYC);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_overflow();
    test_concurrent();
    test_reset_mid();
`ifdef PS2_TX_INHIBIT_EN
    test_inhibit();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_tx_bank.md
Name: ps2_tx_bank

Overview:
- Parametrised bank of NUM_CH independent PS/2 device-side transmitters, each fed by its own byte FIFO.
- Successor to the fixed two-channel keyboard/mouse PS/2 emulation in the MiST user I/O path.
- Runs on one system clock; PS/2 bit timing comes from an internal prescaler, so no separate ps2 clock domain.
- Bytes from the SPI command decoder are written with a channel index; each channel drives its own ps2 clock/data pair towards the core's PS/2 controller.

Parameters:
- NUM_CH, 2, number of PS/2 channels (1..8)
- FIFO_BITS, 3, log2 FIFO depth per channel (depth 2**FIFO_BITS)
- CLK_DIV, 1000, system clocks per half-bit tick (>=2)
- GAP_TICKS, 4, idle half-bit ticks inserted between frames (>=1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_stb  in  1  write strobe, one byte per cycle
- wr_chan  in  3  target channel index
- wr_data  in  8  byte to queue
- clr_overflow  in  NUM_CH  per-channel pulse, clears sticky overflow
- ps2_clk_o  out  NUM_CH  PS/2 clock per channel, idle high
- ps2_data_o  out  NUM_CH  PS/2 data per channel, idle high
- fifo_full  out  NUM_CH  FIFO full
- fifo_empty  out  NUM_CH  FIFO empty
- overflow  out  NUM_CH  sticky: byte dropped on full FIFO
- busy  out  NUM_CH  transmitter not IDLE

Behaviour:
- Reset: prescaler 0, all FIFOs empty (pointers 0), ps2_clk_o=all 1, ps2_data_o=all 1, fifo_full=0, fifo_empty=all 1, overflow=0, busy=0, every channel IDLE.
- Prescaler counts 0..CLK_DIV-1. tick is a one-cycle pulse when the count equals CLK_DIV-1; the count then wraps to 0. The tick is shared by all channels.
- FIFO pointers are FIFO_BITS+1 wide.
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
- Write accepted when wr_stb=1, wr_chan<NUM_CH, and (not full OR a pop occurs on that channel in the same cycle).
- Write to a full FIFO with no pop: byte dropped, overflow[ch] set the next cycle.
- Write with wr_chan>=NUM_CH: ignored, no flag.
- clr_overflow[ch] clears overflow[ch]. If a set and a clear coincide, set wins.
- Transmitter states: IDLE, START, DATA, PARITY, STOP, GAP. All transitions happen on tick only.
- IDLE:
  - FIFO non-empty at tick: pop, latch byte, parity = ~^byte (odd parity bit), go to START.
  - Otherwise stay in IDLE.
- Each bit state spans 2 ticks.
  - Half 0: ps2_data_o = bit value, ps2_clk_o = 1.
  - Half 1: ps2_clk_o = 0, data held.
  - The core samples data on the falling clock edge.
- Bit values: START bit 0; DATA bits byte[0]..byte[7], LSB first, index counter 0..7; PARITY bit = latched parity; STOP bit 1.
- After STOP half 1, go to GAP: clk=1, data=1 for GAP_TICKS ticks, then IDLE.
- Frame = 22 ticks + GAP_TICKS. Back-to-back bytes have no extra idle beyond GAP_TICKS.
- busy=1 in every state except IDLE.
- Outputs are registered; they change the cycle after the tick.
- Channels are fully independent; any number of channels may pop on the same tick.
- Reset asserted mid-frame: outputs go high immediately, FIFO contents are discarded, no partial frame is resumed.

Optional Feature:
- Macro PS2_TX_INHIBIT_EN adds input ps2_clk_i [NUM_CH], the sampled line, synchronised internally with 2 flops.
- With the macro defined:
  - Synchronised ps2_clk_i[ch]=0 while ps2_clk_o[ch]=1 in START..PARITY counts as host inhibit.
  - On inhibit, the channel aborts, drives clk=1/data=1, and enters HOLD.
  - HOLD waits for the line to be high for 2 consecutive ticks, then retransmits the same latched byte from START. The FIFO is not popped again.
  - Inhibit during STOP or GAP is ignored; the frame counts as delivered.
  - In IDLE, a low line blocks the pop until it is released.
- Without the macro: no ps2_clk_i port, no HOLD state, frames are never aborted.

Test Plan:
- CLK_DIV=4, GAP_TICKS=4: write 0x1C to ch0 -> data sequence 0,0,0,1,1,1,0,0,0,0,1 (start, LSB-first data, parity 0, stop); 11 clock-low pulses, each low for 4 clocks; busy high for 26 ticks = 104 clocks.
- Write 0x00 to ch1 -> parity bit 1. Write 0xFF -> parity bit 1. Channel 0 lines stay high throughout.
- FIFO_BITS=3: write 9 bytes to ch0 back-to-back before the first tick -> fifo_full after the 8th write; 9th byte dropped, overflow[0]=1; 8 frames emitted in order; clr_overflow[0] -> overflow[0]=0.
- Simultaneous writes alternating ch0/ch1 on consecutive cycles, 3 bytes each -> both channels emit concurrently with identical tick alignment and correct byte order.
- Assert reset_n=0 during DATA bit 4 -> all outputs 1 within the assertion, fifo_empty=all 1; after release, no frame until a new write.
- PS2_TX_INHIBIT_EN: pull ps2_clk_i[0] low during DATA bit 2 of byte 0xA5 for 10 ticks -> abort, HOLD; after release plus 2 ticks, a complete 0xA5 frame; the next FIFO byte follows only after that frame.
